// File: rtl/debug_ctrl.sv
// debug_ctrl: DMI-to-core debug controller (halt, PC reset pulse, GPR access); ports: dmi_req_*/dmi_resp_* DTM handshake, jtag_* core debug port; optional resetreq via DEBUG_CTRL_RESET_EN
module debug_ctrl #(
  parameter int unsigned HALT_SETTLE_CYCLES = 4,
  parameter int unsigned RESET_PULSE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  input  logic [1:0]  dmi_req_op_i,
  input  logic [6:0]  dmi_req_addr_i,
  input  logic [31:0] dmi_req_data_i,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic [31:0] dmi_resp_data_o,
  output logic        dmi_resp_err_o,
  output logic [4:0]  jtag_reg_addr_o,
  output logic [31:0] jtag_reg_data_o,
  output logic        jtag_reg_we_o,
  input  logic [31:0] jtag_reg_data_i,
  output logic        jtag_halt_flag_o,
  output logic        jtag_reset_flag_o
);
  localparam logic [6:0] A_DATA0 = 7'h04, A_DMCTRL = 7'h10, A_DMSTAT = 7'h11, A_ABSCS = 7'h16, A_CMD = 7'h17;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] data0_q, data0_d, resp_data_q, resp_data_d, rdata;
  logic [2:0] cmderr_q, cmderr_d;
  logic [3:0] halt_cnt_q, halt_cnt_d;
  logic [4:0] regno_q, regno_d;
  logic haltreq_q, haltreq_d, wr_q, wr_d, resp_err_q, resp_err_d;
  logic halted, accept, is_rd, is_wr, mapped, exec;
`ifdef DEBUG_CTRL_RESET_EN
  logic [3:0] rcnt_q, rcnt_d;
  assign jtag_reset_flag_o = rcnt_q != 4'd0;
`else
  assign jtag_reset_flag_o = 1'b0;
`endif
  assign halted = halt_cnt_q == 4'(HALT_SETTLE_CYCLES);
  assign dmi_req_ready_o = (state_q == IDLE) & ~rst;
  assign dmi_resp_valid_o = state_q == RESP;
  assign dmi_resp_data_o = resp_data_q;
  assign dmi_resp_err_o = resp_err_q;
  assign jtag_halt_flag_o = haltreq_q;
  // GPR port is gated by rst so a reset mid-EXEC kills the strobe in the same cycle
  assign exec = (state_q == EXEC) & ~rst;
  assign jtag_reg_we_o = exec & wr_q;
  assign jtag_reg_addr_o = exec ? regno_q : 5'd0;
  assign jtag_reg_data_o = (exec & wr_q) ? data0_q : 32'd0;
  assign accept = dmi_req_valid_i & dmi_req_ready_o;
  assign is_rd = dmi_req_op_i == 2'd1;
  assign is_wr = dmi_req_op_i == 2'd2;
  assign mapped = dmi_req_addr_i inside {A_DATA0, A_DMCTRL, A_DMSTAT, A_ABSCS, A_CMD};
  assign rdata = dmi_req_addr_i == A_DATA0  ? data0_q :
                 dmi_req_addr_i == A_DMCTRL ? {31'd0, haltreq_q} :
                 dmi_req_addr_i == A_DMSTAT ? {31'd0, halted} :
                 dmi_req_addr_i == A_ABSCS  ? {21'd0, cmderr_q, 8'd0} : 32'd0;
  always_comb begin
    state_d = state_q;
    data0_d = data0_q;
    haltreq_d = haltreq_q;
    cmderr_d = cmderr_q;
    regno_d = regno_q;
    wr_d = wr_q;
    resp_data_d = resp_data_q;
    resp_err_d = resp_err_q;
`ifdef DEBUG_CTRL_RESET_EN
    rcnt_d = rcnt_q != 4'd0 ? rcnt_q - 4'd1 : 4'd0;
`endif
    if (state_q == IDLE && accept) begin
      state_d = RESP;
      resp_data_d = is_rd ? rdata : 32'd0;
      resp_err_d = (is_rd | is_wr) & ~mapped;
      if (is_wr && dmi_req_addr_i == A_DATA0) data0_d = dmi_req_data_i;
      if (is_wr && dmi_req_addr_i == A_DMCTRL) begin
        haltreq_d = dmi_req_data_i[0];
`ifdef DEBUG_CTRL_RESET_EN
        if (dmi_req_data_i[1]) rcnt_d = 4'(RESET_PULSE_CYCLES);
`endif
      end
      if (is_wr && dmi_req_addr_i == A_ABSCS) cmderr_d = cmderr_q & ~dmi_req_data_i[10:8];
      // a pending cmderr blocks every command until it is cleared
      if (is_wr && dmi_req_addr_i == A_CMD && cmderr_q == 3'd0 && dmi_req_data_i[17]) begin
        state_d = halted ? EXEC : RESP;
        cmderr_d = halted ? cmderr_q : 3'd4;
        regno_d = dmi_req_data_i[4:0];
        wr_d = dmi_req_data_i[16];
      end
    end else if (state_q == EXEC) begin
      state_d = RESP;
      data0_d = wr_q ? data0_q : jtag_reg_data_i;
    end else if (state_q == RESP && dmi_resp_ready_i) begin
      state_d = IDLE;
    end
    // the counter only advances from a haltreq already held, and clears on the edge haltreq drops
    halt_cnt_d = !haltreq_d ? 4'd0 : (haltreq_q && !halted) ? halt_cnt_q + 4'd1 : halt_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data0_q <= '0;
      haltreq_q <= 1'b0;
      cmderr_q <= '0;
      halt_cnt_q <= '0;
      regno_q <= '0;
      wr_q <= 1'b0;
      resp_data_q <= '0;
      resp_err_q <= 1'b0;
`ifdef DEBUG_CTRL_RESET_EN
      rcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data0_q <= data0_d;
      haltreq_q <= haltreq_d;
      cmderr_q <= cmderr_d;
      halt_cnt_q <= halt_cnt_d;
      regno_q <= regno_d;
      wr_q <= wr_d;
      resp_data_q <= resp_data_d;
      resp_err_q <= resp_err_d;
`ifdef DEBUG_CTRL_RESET_EN
      rcnt_q <= rcnt_d;
`endif
    end
  end
endmodule

// File: doc/debug_ctrl.md
# debug_ctrl

Debug-side controller that drives the core's debug port: halt request, PC reset and GPR read/write (jtag_halt_flag, jtag_reset_flag, jtag_reg_addr/data/we). It sits between a JTAG DTM and cpu_top. It takes single-word register accesses from the DTM over a valid/ready request/response handshake and turns abstract commands into one-cycle GPR accesses on the core.

## Interface
Parameters:
- HALT_SETTLE_CYCLES, 4: cycles haltreq must stay asserted before the core counts as halted (pipeline drain); range 1..15.
- RESET_PULSE_CYCLES, 2: width of the jtag_reset_flag_o pulse; range 1..15.

Ports:
- clk  in  1  core clock (single clock).
- rst  in  1  synchronous, active-high reset.
- dmi_req_valid_i  in  1  request valid.
- dmi_req_ready_o  out  1  request accepted when valid&ready.
- dmi_req_op_i  in  2  0=nop, 1=read, 2=write, 3=reserved (treated as nop).
- dmi_req_addr_i  in  7  DM register address.
- dmi_req_data_i  in  32  write data.
- dmi_resp_valid_o  out  1  response valid.
- dmi_resp_ready_i  in  1  response consumed when valid&ready.
- dmi_resp_data_o  out  32  read data.
- dmi_resp_err_o  out  1  1 = unmapped address.
- jtag_reg_addr_o  out  5  GPR index to core.
- jtag_reg_data_o  out  32  GPR write data to core.
- jtag_reg_we_o  out  1  GPR write strobe.
- jtag_reg_data_i  in  32  GPR read data from core, combinational from jtag_reg_addr_o.
- jtag_halt_flag_o  out  1  core halt request.
- jtag_reset_flag_o  out  1  core PC reset pulse.

## Operation
Register map:
- 0x04 DATA0: 32-bit, R/W.
- 0x10 DMCONTROL:
  - bit0 haltreq: R/W.
  - bit1 resetreq: write-1 pulse, reads 0.
- 0x11 DMSTATUS: bit0 halted, read-only.
- 0x16 ABSTRACTCS:
  - bits[10:8] cmderr: write-1-to-clear.
  - bit12 busy: reads 0 whenever a request can be accepted.
- 0x17 COMMAND: write-only, reads 0.
  - [4:0] regno.
  - bit16 write: 1 = write GPR, 0 = read GPR.
  - bit17 transfer.
- Any other address: read returns 0 with err=1; write is ignored with err=1.

State machine:
- IDLE → RESP for nop, read, or non-transfer write.
- IDLE → EXEC for a COMMAND write with transfer=1 and cmderr==0.
- EXEC → RESP after exactly 1 cycle.
- RESP → IDLE on dmi_resp_ready_i.
- dmi_req_ready_o = (state==IDLE) & ~rst.

Command rules:
- COMMAND with transfer=1 while halted==0: no GPR access, cmderr←4, go straight to RESP.
- COMMAND while cmderr!=0: ignored, no access, go to RESP.
- transfer=0: no access.
- EXEC with write=1: jtag_reg_we_o=1, jtag_reg_addr_o=regno, jtag_reg_data_o=DATA0, for one cycle.
- EXEC with write=0: jtag_reg_addr_o=regno for one cycle; jtag_reg_data_i is captured into DATA0 at the end of that cycle.
- regno 0: the read returns whatever the core returns; the write is issued anyway.

Halt and reset:
- jtag_halt_flag_o = haltreq.
- Halt counter increments while haltreq=1 and saturates at HALT_SETTLE_CYCLES; halted = (count==HALT_SETTLE_CYCLES).
- Clearing haltreq zeroes the counter the same edge, so halted drops the next cycle.
- Writing resetreq=1 loads the pulse counter; jtag_reset_flag_o stays high for RESET_PULSE_CYCLES cycles.
- A resetreq write during an active pulse restarts the count.
- haltreq and resetreq in the same write both take effect.

## Timing
- Reset values: state IDLE; dmi_req_ready_o 0 while rst is high, 1 the cycle after. All other outputs 0; DATA0, haltreq, cmderr and both counters 0.
- Register write side effects take effect at the accept edge.
- Non-command access: response valid the cycle after accept.
- Transfer command: EXEC on cycle +1, response valid on cycle +2.
- dmi_resp_data_o and dmi_resp_err_o stay stable while resp_valid=1 and resp_ready=0.
- Response data is registered at entry to RESP.
- rst mid-EXEC: the strobe drops immediately; no response is issued.

## Configuration
- DEBUG_CTRL_RESET_EN defined: resetreq is implemented as described.
- Undefined:
  - DMCONTROL bit1 is ignored on write.
  - jtag_reset_flag_o is tied to 0.
  - The pulse counter and RESET_PULSE_CYCLES logic are absent.
  - All other behaviour is identical.

## Test plan
- Halt status: write DMCONTROL=0x1 → jtag_halt_flag_o=1 next cycle; DMSTATUS reads 0 until 4 cycles after accept, then 1. Write DMCONTROL=0x0 → DMSTATUS reads 0.
- GPR write: halted; write DATA0=0xDEADBEEF, then COMMAND=0x0003_0005 → exactly one cycle of we=1, addr=5, data=0xDEADBEEF; response on cycle +2, err=0.
- GPR read: halted; core returns 0x12345678 for addr 7; COMMAND=0x0002_0007 then read DATA0 → 0x12345678.
- Command while running: haltreq=0; COMMAND=0x0002_0001 → no GPR access; ABSTRACTCS[10:8]=4. Write ABSTRACTCS=0x700 → cmderr=0.
- Reset pulse: with DEBUG_CTRL_RESET_EN, write DMCONTROL=0x3 → reset_flag high exactly 2 cycles, halt_flag 1. Without the macro → reset_flag stays 0.
- Backpressure: hold resp_ready=0 for 5 cycles after a read of 0x7F → resp_valid, data=0 and err=1 held; req_ready=0 throughout.
